// File: rtl/fm_discriminator.sv
// Polar FM discriminator: iterative CORDIC phase per I/Q sample,
// output is the wrapped phase difference to the previous sample.
module fm_discriminator #(
   parameter int DATA_WIDTH  = 16,
   parameter int PHASE_WIDTH = 16,
   parameter int ITER        = 14
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] ast_sink_i,
   input  logic [DATA_WIDTH-1:0] ast_sink_q,
   input  logic                  ast_sink_valid,
   input  logic [1:0]            ast_sink_error,
   output logic [DATA_WIDTH-1:0] ast_source_data,
   output logic                  ast_source_valid,
   output logic [1:0]            ast_source_error
);

   localparam int XW = DATA_WIDTH + 2;
   localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);
   localparam logic [PHASE_WIDTH-1:0] HALF = PHASE_WIDTH'(1) << (PHASE_WIDTH - 1);
   localparam logic [32:0] RND = 33'd1 << (31 - PHASE_WIDTH);

   // atan(2^-k) in units of 2^-32 of a full circle
   localparam logic [31:0] ATAN32 [32] = '{
      32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
      32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
      32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
      32'd166886,    32'd83443,     32'd41722,     32'd20861,
      32'd10430,     32'd5215,      32'd2608,      32'd1304,
      32'd652,       32'd326,       32'd163,       32'd81,
      32'd41,        32'd20,        32'd10,        32'd5,
      32'd3,         32'd1,         32'd1,         32'd0
   };

   function automatic logic [PHASE_WIDTH-1:0] atan_k(input logic [KW-1:0] kk);
      logic [32:0] r;
      r = {1'b0, ATAN32[5'(kk)]} + RND;
      r = r >> (32 - PHASE_WIDTH);
      return r[PHASE_WIDTH-1:0];
   endfunction

   typedef enum logic [1:0] {IDLE, PRE, ROT, DIFF} state_t;

   state_t                  state;
   logic signed [XW-1:0]    x, y;
   logic [PHASE_WIDTH-1:0]  z, prev_phase;
   logic [KW-1:0]           k;
   logic                    zero_in, first;
   logic                    drop, drop_cur, err;

   logic signed [XW-1:0]    xs, ys;
   logic [PHASE_WIDTH-1:0]  phase, d;

   assign xs    = x >>> k;
   assign ys    = y >>> k;
   assign phase = zero_in ? prev_phase : z;
   assign d     = phase - prev_phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         x                <= '0;
         y                <= '0;
         z                <= '0;
         k                <= '0;
         prev_phase       <= '0;
         zero_in          <= 1'b0;
         first            <= 1'b1;
         drop             <= 1'b0;
         drop_cur         <= 1'b0;
         err              <= 1'b0;
         ast_source_data  <= '0;
         ast_source_valid <= 1'b0;
         ast_source_error <= '0;
      end else begin
         ast_source_valid <= 1'b0;
         if (ast_sink_valid && state != IDLE)
            drop <= 1'b1;
         unique case (state)
            IDLE: begin
               if (ast_sink_valid) begin
                  x        <= {{2{ast_sink_i[DATA_WIDTH-1]}}, ast_sink_i};
                  y        <= {{2{ast_sink_q[DATA_WIDTH-1]}}, ast_sink_q};
                  err      <= err | (|ast_sink_error);
                  // drops seen so far belong to this sample's word
                  drop_cur <= drop_cur | drop;
                  drop     <= 1'b0;
                  state    <= PRE;
               end
            end
            PRE: begin
               if (x[XW-1]) begin
                  x <= -x;
                  y <= -y;
                  z <= HALF;
               end else begin
                  z <= '0;
               end
               zero_in <= (x == '0) && (y == '0);
               k       <= '0;
               state   <= ROT;
            end
            ROT: begin
               if (!y[XW-1]) begin
                  x <= x + ys;
                  y <= y - xs;
                  z <= z + atan_k(k);
               end else begin
                  x <= x - ys;
                  y <= y + xs;
                  z <= z - atan_k(k);
               end
               k <= k + 1'b1;
               if (k == K_LAST)
                  state <= DIFF;
            end
            DIFF: begin
               prev_phase <= phase;
               if (first) begin
                  first <= 1'b0;
               end else begin
                  ast_source_data  <= d[PHASE_WIDTH-1 -: DATA_WIDTH];
                  ast_source_valid <= 1'b1;
                  ast_source_error <= {err, drop_cur};
                  err              <= 1'b0;
                  drop_cur         <= 1'b0;
               end
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fm_discriminator.sv
// Bench for fm_discriminator: directed and random phasors against
// a floating-point atan2 reference of the instantaneous frequency.
module tb_fm_discriminator;

   localparam int  DW   = 16;
   localparam int  PW   = 16;
   localparam int  ITER = 14;
   localparam real PI   = 3.14159265358979;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] ast_sink_i = '0;
   logic [DW-1:0] ast_sink_q = '0;
   logic          ast_sink_valid = 1'b0;
   logic [1:0]    ast_sink_error = '0;
   logic [DW-1:0] ast_source_data;
   logic          ast_source_valid;
   logic [1:0]    ast_source_error;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int q_data[$];
   int q_err[$];
   int q_cyc[$];

   real ref_prev  = 0.0;
   bit  ref_first = 1'b1;
   bit  ref_err   = 1'b0;
   bit  ref_drop  = 1'b0;

   fm_discriminator #(
      .DATA_WIDTH (DW),
      .PHASE_WIDTH(PW),
      .ITER       (ITER)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .ast_sink_i      (ast_sink_i),
      .ast_sink_q      (ast_sink_q),
      .ast_sink_valid  (ast_sink_valid),
      .ast_sink_error  (ast_sink_error),
      .ast_source_data (ast_source_data),
      .ast_source_valid(ast_source_valid),
      .ast_source_error(ast_source_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ast_source_valid === 1'b1) begin
         q_data.push_back(int'($signed(ast_source_data)));
         q_err.push_back(int'(ast_source_error));
         q_cyc.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input int obs,
                             input int exp, input int tol);
      int df;
      bit ok;
      df = obs - exp;
      df = ((df % 65536) + 65536 + 32768) % 65536 - 32768;
      ok = (df <= tol) && (df >= -tol);
      n_chk++;
      assert (ok === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d +/-%0d",
                tag, obs, exp, tol);
      end
   endtask

   function automatic int exp_d(input real a, input real p);
      real dd;
      dd = (a - p) * 65536.0 / (2.0 * PI);
      while (dd >= 32768.0) dd -= 65536.0;
      while (dd < -32768.0) dd += 65536.0;
      return int'(dd);
   endfunction

   function automatic real angle_of(input int i, input int q);
      if (i == 0 && q == 0)
         return ref_prev;
      return $atan2(real'(q), real'(i));
   endfunction

   task automatic send(input int i, input int q,
                       input logic [1:0] e, output int tacc);
      @(negedge clk);
      ast_sink_i     = DW'(i);
      ast_sink_q     = DW'(q);
      ast_sink_error = e;
      ast_sink_valid = 1'b1;
      @(negedge clk);
      ast_sink_valid = 1'b0;
      ast_sink_error = '0;
      tacc = cyc;
   endtask

   task automatic expect_word(input string tag, input real a,
                              input int tacc, input int tol);
      int d, er, c;
      check({tag, "_count"}, q_data.size(), 1);
      if (q_data.size() > 0) begin
         d  = q_data.pop_front();
         er = q_err.pop_front();
         c  = q_cyc.pop_front();
         check_near({tag, "_mpx"}, d, exp_d(a, ref_prev), tol);
         check({tag, "_err"}, er, int'({ref_err, ref_drop}));
         check({tag, "_lat"}, c - tacc, ITER + 2);
         ref_err  = 1'b0;
         ref_drop = 1'b0;
      end
   endtask

   task automatic step(input string tag, input int i, input int q,
                       input logic [1:0] e, input int tol);
      int  tacc;
      real a;
      send(i, q, e, tacc);
      repeat (19) @(negedge clk);
      a = angle_of(i, q);
      ref_err = ref_err | (e != 2'b00);
      if (ref_first)
         check({tag, "_first"}, q_data.size(), 0);
      else
         expect_word(tag, a, tacc, tol);
      ref_prev  = a;
      ref_first = 1'b0;
      q_data.delete();
      q_err.delete();
      q_cyc.delete();
   endtask

   function automatic int polar_i(input real amp, input real deg);
      return int'(amp * $cos(deg * PI / 180.0));
   endfunction

   function automatic int polar_q(input real amp, input real deg);
      return int'(amp * $sin(deg * PI / 180.0));
   endfunction

   initial begin
      int  tacc;
      real a;
      real deg;
      real amp;

      repeat (2) @(negedge clk);
      check("rst_data", int'(ast_source_data), 0);
      check("rst_valid", int'(ast_source_valid), 0);
      check("rst_err", int'(ast_source_error), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int n = 0; n < 4; n++)
         step("const", 16384, 0, 2'b00, 2);

      step("p45", 16384, 0, 2'b00, 4);
      step("p45", 11585, 11585, 2'b00, 4);
      step("p45", 0, 16384, 2'b00, 4);
      step("p45", -11585, 11585, 2'b00, 4);

      step("m90", 0, 16384, 2'b00, 4);
      step("m90", 16384, 0, 2'b00, 4);
      step("m90", 0, -16384, 2'b00, 4);

      step("wrap", polar_i(20000.0, 170.0), polar_q(20000.0, 170.0), 2'b00, 4);
      step("wrap", polar_i(20000.0, -170.0), polar_q(20000.0, -170.0), 2'b00, 4);
      check_near("wrap_ref", exp_d($atan2(-1.0, -5.67), $atan2(1.0, -5.67)),
                 3641, 4);

      step("ovr", 16384, 0, 2'b00, 4);
      send(11585, 11585, 2'b00, tacc);
      @(negedge clk);
      @(negedge clk);
      ast_sink_i     = DW'(0);
      ast_sink_q     = DW'(-16384);
      ast_sink_valid = 1'b1;
      @(negedge clk);
      ast_sink_valid = 1'b0;
      repeat (17) @(negedge clk);
      a = angle_of(11585, 11585);
      expect_word("ovr_a", a, tacc, 4);
      ref_prev = a;
      ref_drop = 1'b1;
      q_data.delete();
      q_err.delete();
      q_cyc.delete();
      step("ovr_b", 0, 16384, 2'b00, 4);
      step("uperr", 16384, 0, 2'b01, 4);
      step("clean", 11585, -11585, 2'b00, 4);

      step("zero", 16384, 0, 2'b00, 4);
      step("zero", 0, 0, 2'b00, 2);
      step("zero", 16384, 0, 2'b00, 2);

      step("big", -32768, -32768, 2'b00, 4);

      send(0, 16384, 2'b00, tacc);
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_data", int'(ast_source_data), 0);
      check("mid_rst_valid", int'(ast_source_valid), 0);
      check("mid_rst_err", int'(ast_source_error), 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("mid_rst_no_pulse", q_data.size(), 0);
      ref_first = 1'b1;
      ref_prev  = 0.0;
      ref_err   = 1'b0;
      ref_drop  = 1'b0;
      step("post_rst", 0, 16384, 2'b00, 4);
      step("post_rst", 16384, 0, 2'b00, 4);

      for (int n = 0; n < 20; n++) begin
         deg = real'($urandom_range(0, 35999)) / 100.0;
         amp = real'($urandom_range(12000, 32000));
         step("rand", polar_i(amp, deg), polar_q(amp, deg), 2'b00, 8);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
